// File: rtl/sixteen_bit_priority_encoder.sv
// rtl/sixteen_bit_priority_encoder.sv - registered 16-input priority encoder
// Optional macro PRIOENC_MULTI_EN adds a registered "two or more requests" flag.
module sixteen_bit_priority_encoder #(
    parameter int LSB_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] A,
    output logic [3:0]  Y,
    output logic        valid
`ifdef PRIOENC_MULTI_EN
    ,
    output logic        multi
`endif
);

    logic [3:0] w_idx;
    logic       w_any;
    logic [3:0] r_y;
    logic       r_valid;

    // Later loop iterations overwrite earlier ones, so scan order sets priority.
    always_comb begin
        w_idx = 4'd0;
        if (LSB_PRIORITY == 0) begin
            for (int i = 0; i < 16; i++) begin
                if (A[i]) w_idx = 4'(i);
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (A[i]) w_idx = 4'(i);
            end
        end
    end

    assign w_any = |A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= 4'd0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_y     <= w_idx;
            r_valid <= w_any;
        end
    end

    assign Y     = r_y;
    assign valid = r_valid;

`ifdef PRIOENC_MULTI_EN
    logic w_multi;
    logic r_multi;

    // Clearing the lowest set bit leaves something behind only if 2+ bits were set.
    assign w_multi = |(A & (A - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_multi <= 1'b0;
        end else if (en) begin
            r_multi <= w_multi;
        end
    end

    assign multi = r_multi;
`endif

endmodule

// File: tb/tb_sixteen_bit_priority_encoder.sv
// tb/tb_sixteen_bit_priority_encoder.sv - scoreboard bench for sixteen_bit_priority_encoder
module tb_sixteen_bit_priority_encoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] A;
    logic [3:0]  y_msb;
    logic        valid_msb;
    logic [3:0]  y_lsb;
    logic        valid_lsb;
`ifdef PRIOENC_MULTI_EN
    logic        multi_msb;
    logic        multi_lsb;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] y_msb;
        logic [3:0] y_lsb;
        logic       valid;
        logic       multi;
    } exp_t;

    exp_t sb_q[$];

    logic [3:0] m_y_msb;
    logic [3:0] m_y_lsb;
    logic       m_valid;
    logic       m_multi;

    sixteen_bit_priority_encoder #(.LSB_PRIORITY(0)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (A),
        .Y     (y_msb),
        .valid (valid_msb)
`ifdef PRIOENC_MULTI_EN
        ,
        .multi (multi_msb)
`endif
    );

    sixteen_bit_priority_encoder #(.LSB_PRIORITY(1)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (A),
        .Y     (y_lsb),
        .valid (valid_lsb)
`ifdef PRIOENC_MULTI_EN
        ,
        .multi (multi_lsb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_msb(input logic [15:0] a);
        logic [15:0] t;
        logic [3:0]  idx;
        t   = a;
        idx = 4'd0;
        while (t > 16'd1) begin
            t   = t >> 1;
            idx = idx + 4'd1;
        end
        return idx;
    endfunction

    function automatic logic [3:0] ref_lsb(input logic [15:0] a);
        logic [15:0] t;
        logic [3:0]  idx;
        t   = a;
        idx = 4'd0;
        if (a == 16'd0) return 4'd0;
        while (t[0] == 1'b0) begin
            t   = t >> 1;
            idx = idx + 4'd1;
        end
        return idx;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_y_msb = 4'd0;
        m_y_lsb = 4'd0;
        m_valid = 1'b0;
        m_multi = 1'b0;
    endtask

    task automatic compare_now(input exp_t e);
        check({e.tag, ".y_msb"}, {4'd0, y_msb}, {4'd0, e.y_msb});
        check({e.tag, ".valid_msb"}, {7'd0, valid_msb}, {7'd0, e.valid});
        check({e.tag, ".y_lsb"}, {4'd0, y_lsb}, {4'd0, e.y_lsb});
        check({e.tag, ".valid_lsb"}, {7'd0, valid_lsb}, {7'd0, e.valid});
`ifdef PRIOENC_MULTI_EN
        check({e.tag, ".multi_msb"}, {7'd0, multi_msb}, {7'd0, e.multi});
        check({e.tag, ".multi_lsb"}, {7'd0, multi_lsb}, {7'd0, e.multi});
`endif
    endtask

    // Drive on the falling edge, push the expectation, compare just after the rising edge.
    task automatic step(input logic e, input logic [15:0] a, input string tag);
        exp_t ex;
        @(negedge clk);
        en = e;
        A  = a;
        if (!rst_n) begin
            model_reset();
        end else if (e) begin
            m_y_msb = ref_msb(a);
            m_y_lsb = ref_lsb(a);
            m_valid = (a != 16'd0);
            m_multi = ($countones(a) >= 2);
        end
        ex.tag   = tag;
        ex.y_msb = m_y_msb;
        ex.y_lsb = m_y_lsb;
        ex.valid = m_valid;
        ex.multi = m_multi;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        compare_now(sb_q.pop_front());
    endtask

    initial begin
        exp_t ex;
        rst_n = 1'b0;
        en    = 1'b1;
        A     = 16'hFFFF;
        model_reset();
        #1;
        ex = '{tag: "rst_t0", y_msb: 4'd0, y_lsb: 4'd0, valid: 1'b0, multi: 1'b0};
        compare_now(ex);

        for (int i = 0; i < 4; i++) step(1'b1, 16'hFFFF, "rst_hold");

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) step(1'b1, 16'h0001 << i, $sformatf("onehot%0d", i));

        step(1'b1, 16'h0000, "zero");
        step(1'b1, 16'h0001, "zero_then_bit0");

        step(1'b1, 16'h0006, "p0006");
        step(1'b1, 16'h0012, "p0012");
        step(1'b1, 16'h00A0, "p00A0");
        step(1'b1, 16'h1001, "p1001");
        step(1'b1, 16'h6000, "p6000");
        step(1'b1, 16'hFFFF, "pFFFF");
        step(1'b1, 16'h8000, "p8000");
        step(1'b1, 16'h0010, "p0010");

        step(1'b1, 16'h0100, "hold_load");
        for (int i = 0; i < 3; i++) step(1'b0, 16'h8000, "hold_en0");
        step(1'b1, 16'h8000, "hold_release");

        // Asynchronous reset a few ns after the edge, checked before the next edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        ex = '{tag: "async_rst", y_msb: 4'd0, y_lsb: 4'd0, valid: 1'b0, multi: 1'b0};
        compare_now(ex);
        step(1'b1, 16'hFFFF, "rst_overrides_en");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h0012, "post_rst");
        step(1'b1, 16'h3C00, "post_rst2");

        check("sb_empty", 8'(sb_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
